oversampled_bit_receiver: RTL and testbench
===========================================

OVERSAMPLED_BIT_RECEIVER -- requirements
Module: oversampled_bit_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 128, meaning clk cycles per bit (180 MHz / 1.40625 MHz); must be a power of two, at least 8.
REQ-002 SHALL have parameter SYNC_WORD, 16 bits, default 16'h1ACF, meaning the frame sync pattern, MSB first; must be non-zero.
REQ-003 SHALL have parameter MAX_RUN, default 16, meaning the maximum number of consecutive bits without a transition while locked.
REQ-004 clk  in  1  oversampling clock, 180 MHz recovered-clock PLL output; sole clock.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 pll_locked  in  1  PLL lock indication; asynchronous, synchronised internally by 2 flops.
REQ-007 serial_in  in  1  asynchronous NRZ serial line.
REQ-008 bit_valid  out  1  one-cycle strobe per recovered bit.
REQ-009 bit_data  out  1  recovered bit; valid when bit_valid=1.
REQ-010 lock  out  1  high while the framer is in LOCKED.
REQ-011 sync_found  out  1  one-cycle pulse on sync word match.
REQ-012 byte_data  out  8  recovered byte, MSB first; held between strobes.
REQ-013 byte_valid  out  1  one-cycle strobe; byte_data valid.
REQ-014 run_err  out  1  one-cycle pulse on run-length violation.

Function
REQ-015 serial_in SHALL pass a 2-flop synchroniser, then a 3-tap shift register; the filtered line f is the registered majority of the 3 taps, so single-cycle glitches are rejected.
REQ-016 An edge SHALL be flagged in any cycle where f differs from its previous-cycle value.
REQ-017 The log2(OVERSAMPLE)-bit phase counter SHALL load 1 on an edge, otherwise increment modulo OVERSAMPLE.
REQ-018 The sample point SHALL be phase == OVERSAMPLE/2; bit_valid and bit_data (= f) SHALL register one cycle after the sample point.
REQ-019 An edge coinciding with the sample point SHALL take priority: the phase resets and no bit is sampled that period.
REQ-020 Run counter behaviour: clears on every edge; increments on every sampled bit; saturates at MAX_RUN.
REQ-021 Framer states SHALL be HUNT and LOCKED.
  - HUNT: the 16-bit window shifts in each bit; window == SYNC_WORD moves to LOCKED, clears the bit counter, and pulses sync_found one cycle after that bit's bit_valid.
  - LOCKED: 8 bits are accumulated MSB first; byte_valid pulses, and byte_data updates, one cycle after the 8th bit_valid; the counter wraps to 0 (no gap between bytes).
REQ-022 LOCKED SHALL return to HUNT when the run counter reaches MAX_RUN, pulsing run_err in the same cycle lock falls.
REQ-023 LOCKED SHALL return to HUNT in the cycle after synchronised pll_locked is low; no run_err pulse is generated in this case.
REQ-024 Any return to HUNT SHALL discard the partial byte (no byte_valid for it) and clear the window to 0.
REQ-025 While synchronised pll_locked is low, the framer SHALL stay in HUNT and ignore window matches; bit recovery continues.
REQ-026 If a sync match and a run violation occur in the same cycle, the run violation SHALL take priority.
REQ-027 Latency: serial_in transition to edge flag is 4 cycles (2 sync + 1 tap + 1 filter register).

Reset
REQ-028 With rst_n low at a clk edge, all of the following SHALL clear to 0:
  - synchroniser, taps, f, phase, run counter, window and bit counter;
  - bit_valid, bit_data, lock, sync_found, byte_data, byte_valid, run_err.
  The framer SHALL enter HUNT.
REQ-029 Reset mid-byte SHALL abort the byte with no strobe; the first bit_valid after reset SHALL follow a detected edge or a full OVERSAMPLE period.

Verification
REQ-030 Reset check: hold rst_n low 4 cycles with serial_in toggling -> every output is 0 and lock is 0 on the first cycle after release.
REQ-031 Nominal frame: pll_locked=1; send 0x1ACF then 0x3C, 0xA5 at 128 clk/bit -> exactly one sync_found; byte_valid twice, with byte_data 0x3C then 0xA5; lock=1.
REQ-032 Drift tolerance: the same frame followed by 64 bytes of 0x55/0x0F at a bit period of 127, then 129 cycles -> all bytes correct, no run_err.
REQ-033 Run violation: after lock, send 16 consecutive 1 bits -> run_err pulses once and lock falls in that cycle; no further byte_valid until a new 0x1ACF is received.
REQ-034 Loss of PLL lock: deassert pll_locked after 5 bits of a byte -> lock low within 3 cycles; no byte_valid; after reasserting, a resent sync plus 0x81 -> byte_data=0x81.
REQ-035 Glitch rejection: inject a 1-cycle pulse at phase 30 of a constant-0 bit -> no edge and no phase reset; the recovered bit is 0.

Source files
------------

// File: rtl/oversampled_bit_receiver.sv
// rtl/oversampled_bit_receiver.sv - oversampled NRZ bit recovery with sync-word byte framer
module oversampled_bit_receiver #(
  parameter int          OVERSAMPLE = 128,
  parameter logic [15:0] SYNC_WORD  = 16'h1ACF,
  parameter int          MAX_RUN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       serial_in,
  output logic       bit_valid,
  output logic       bit_data,
  output logic       lock,
  output logic       sync_found,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       run_err
);

  localparam int            PW           = $clog2(OVERSAMPLE);
  localparam int            RW           = $clog2(MAX_RUN + 1);
  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] LAST_PHASE   = PW'(OVERSAMPLE - 1);
  localparam logic [RW-1:0] RUN_MAX      = RW'(MAX_RUN);
  localparam logic [RW-1:0] RUN_LAST     = RW'(MAX_RUN - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // line conditioning and bit timing
  logic          r_sin_s1;
  logic          r_sin_s2;
  logic [2:0]    r_tap;
  logic          r_f;
  logic [PW-1:0] r_phase;
  logic          r_armed;
  logic          r_bit_valid;
  logic          r_bit_data;
  logic [RW-1:0] r_run;

  // pll lock synchroniser
  logic          r_pll_s1;
  logic          r_pll_s2;

  // framer
  state_t        r_state;
  logic [15:0]   r_window;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shreg;
  logic [7:0]    r_byte_data;
  logic          r_byte_valid;
  logic          r_sync_found;
  logic          r_run_err;

  logic          w_maj;
  logic          w_edge;
  logic          w_sample;
  logic          w_run_hit;
  logic [15:0]   w_window_shift;

  state_t        w_state_nxt;
  logic [15:0]   w_window_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [6:0]    w_shreg_nxt;
  logic [7:0]    w_byte_data_nxt;
  logic          w_byte_valid_nxt;
  logic          w_sync_found_nxt;
  logic          w_run_err_nxt;

  // Majority of the three taps: a single-cycle glitch can occupy only one tap.
  assign w_maj = (r_tap[0] & r_tap[1]) | (r_tap[0] & r_tap[2]) | (r_tap[1] & r_tap[2]);

  // The edge is flagged in the cycle f takes its new value, so phase reads 1
  // on the first cycle of the new level.
  assign w_edge = (w_maj != r_f);

  // Sampling waits for the first edge or one full period after reset so the
  // first recovered bit is never taken from a half-formed period.
  assign w_sample = r_armed && !w_edge && (r_phase == SAMPLE_PHASE);

  // The run limit is reached on the sampled bit that would take the count to MAX_RUN.
  assign w_run_hit = !w_edge && r_bit_valid && (r_run == RUN_LAST);

  assign w_window_shift = {r_window[14:0], r_bit_data};

  // Synchronisers, glitch filter, phase counter and bit sampler
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sin_s1    <= 1'b0;
      r_sin_s2    <= 1'b0;
      r_tap       <= 3'b000;
      r_f         <= 1'b0;
      r_phase     <= '0;
      r_armed     <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_data  <= 1'b0;
      r_pll_s1    <= 1'b0;
      r_pll_s2    <= 1'b0;
    end else begin
      r_sin_s1    <= serial_in;
      r_sin_s2    <= r_sin_s1;
      r_tap       <= {r_tap[1:0], r_sin_s2};
      r_f         <= w_maj;
      r_pll_s1    <= pll_locked;
      r_pll_s2    <= r_pll_s1;
      if (w_edge) begin
        r_phase <= {{(PW-1){1'b0}}, 1'b1};
        r_armed <= 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
        if (r_phase == LAST_PHASE) begin
          r_armed <= 1'b1;
        end
      end
      r_bit_valid <= w_sample;
      if (w_sample) begin
        r_bit_data <= r_f;
      end
    end
  end

  // Run-length counter: cleared by edges, counts recovered bits, saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run <= '0;
    end else if (w_edge) begin
      r_run <= '0;
    end else if (r_bit_valid && (r_run != RUN_MAX)) begin
      r_run <= r_run + 1'b1;
    end
  end

  // Framer state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_window     <= 16'h0000;
      r_bit_cnt    <= 3'd0;
      r_shreg      <= 7'd0;
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
      r_sync_found <= 1'b0;
      r_run_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_window     <= w_window_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_byte_data  <= w_byte_data_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_sync_found <= w_sync_found_nxt;
      r_run_err    <= w_run_err_nxt;
    end
  end

  // Framer next state: hunt for the sync word, then assemble bytes until lock is lost
  always_comb begin
    w_state_nxt      = r_state;
    w_window_nxt     = r_window;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shreg_nxt      = r_shreg;
    w_byte_data_nxt  = r_byte_data;
    w_byte_valid_nxt = 1'b0;
    w_sync_found_nxt = 1'b0;
    w_run_err_nxt    = 1'b0;
    case (r_state)
      HUNT: begin
        if (r_bit_valid) begin
          w_window_nxt = w_window_shift;
          // A run violation on the same bit vetoes the match.
          if (r_pll_s2 && !w_run_hit && (w_window_shift == SYNC_WORD)) begin
            w_state_nxt      = LOCKED;
            w_bit_cnt_nxt    = 3'd0;
            w_sync_found_nxt = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!r_pll_s2) begin
          w_state_nxt   = HUNT;
          w_window_nxt  = 16'h0000;
          w_bit_cnt_nxt = 3'd0;
        end else if (w_run_hit) begin
          w_state_nxt   = HUNT;
          w_window_nxt  = 16'h0000;
          w_bit_cnt_nxt = 3'd0;
          w_run_err_nxt = 1'b1;
        end else if (r_bit_valid) begin
          w_shreg_nxt = {r_shreg[5:0], r_bit_data};
          if (r_bit_cnt == 3'd7) begin
            w_byte_data_nxt  = {r_shreg, r_bit_data};
            w_byte_valid_nxt = 1'b1;
            w_bit_cnt_nxt    = 3'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  assign bit_valid  = r_bit_valid;
  assign bit_data   = r_bit_data;
  assign lock       = (r_state == LOCKED);
  assign sync_found = r_sync_found;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign run_err    = r_run_err;

endmodule

// File: tb/tb_oversampled_bit_receiver.sv
// tb/tb_oversampled_bit_receiver.sv - directed and randomized bench for oversampled_bit_receiver
module tb_oversampled_bit_receiver;

  localparam int          OS   = 64;
  localparam int          MAXR = 16;
  localparam logic [15:0] SYNC = 16'h1ACF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       serial_in = 1'b0;
  logic       bit_valid;
  logic       bit_data;
  logic       lock;
  logic       sync_found;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       run_err;

  int total = 0;
  int bad = 0;

  oversampled_bit_receiver #(
    .OVERSAMPLE(OS),
    .SYNC_WORD (SYNC),
    .MAX_RUN   (MAXR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .lock      (lock),
    .sync_found(sync_found),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .run_err   (run_err)
  );

  always #5 clk = ~clk;

  // observed event history, written only by the monitor
  int         cyc = 0;
  logic       got_bits[$];
  int         got_bit_cyc[$];
  logic [7:0] got_bytes[$];
  int         got_nsync = 0;
  int         got_nrun = 0;
  int         got_rl_bad = 0;
  logic       prev_lock = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bit_valid === 1'b1) begin
      got_bits.push_back(bit_data);
      got_bit_cyc.push_back(cyc);
    end
    if (byte_valid === 1'b1) got_bytes.push_back(byte_data);
    if (sync_found === 1'b1) got_nsync++;
    if (run_err === 1'b1) begin
      got_nrun++;
      if (lock !== 1'b0 || prev_lock !== 1'b1) got_rl_bad++;
    end
    prev_lock = lock;
  end

  // stimulus record and reference expectations
  logic       sent_bits[$];
  logic       sent_pll[$];
  logic [7:0] exp_bytes[$];
  int         exp_nsync;
  int         exp_nrun;
  logic       exp_lock;
  int b_bits, b_bytes, b_sync, b_run, b_rl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    serial_in = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic begin_scn();
    sent_bits.delete();
    sent_pll.delete();
    b_bits  = got_bits.size();
    b_bytes = got_bytes.size();
    b_sync  = got_nsync;
    b_run   = got_nrun;
    b_rl    = got_rl_bad;
  endtask

  // one bit of `per` cycles; optional single-cycle inverted pulse at offset gpos
  task automatic send_bit(input logic b, input int per, input int gpos);
    sent_bits.push_back(b);
    sent_pll.push_back(pll_locked);
    for (int c = 0; c < per; c++) begin
      serial_in = (c == gpos) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int per, input int gpos);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], per, (v[i] == 1'b0) ? gpos : -1);
    end
  endtask

  task automatic send_frame_head(input int per);
    send_byte(8'hAA, per, -1);
    send_byte(SYNC[15:8], per, -1);
    send_byte(SYNC[7:0], per, -1);
  endtask

  // Bit-stream reference: runs of equal bits, sliding sync window, byte assembly.
  task automatic run_model();
    logic [15:0] win;
    logic [7:0]  acc;
    logic        prev;
    logic        b;
    int          run;
    int          old;
    int          cnt;
    bit          locked;
    bit          hit;
    win = 16'h0; acc = 8'h0; prev = 1'b0; run = 0; cnt = 0; locked = 0;
    exp_bytes.delete();
    exp_nsync = 0;
    exp_nrun = 0;
    foreach (sent_bits[i]) begin
      b = sent_bits[i];
      old = run;
      if (b != prev) run = 1;
      else if (run < MAXR) run = run + 1;
      hit = (run == MAXR) && (old != MAXR);
      prev = b;
      if (!sent_pll[i]) begin
        if (locked) begin
          locked = 0;
          win = 16'h0;
        end
        win = {win[14:0], b};
      end else if (!locked) begin
        win = {win[14:0], b};
        if (win == SYNC && !hit) begin
          locked = 1;
          cnt = 0;
          exp_nsync++;
        end
      end else if (hit) begin
        locked = 0;
        win = 16'h0;
        exp_nrun++;
      end else begin
        acc = {acc[6:0], b};
        cnt++;
        if (cnt == 8) begin
          exp_bytes.push_back(acc);
          cnt = 0;
        end
      end
    end
    exp_lock = locked;
  endtask

  task automatic check_scn(input string tag);
    int nb;
    int nby;
    int mism;
    run_model();
    nb = got_bits.size() - b_bits;
    nby = got_bytes.size() - b_bytes;
    chk({tag, " bit count"}, nb, sent_bits.size());
    mism = 0;
    for (int i = 0; i < nb && i < sent_bits.size(); i++) begin
      if (got_bits[b_bits + i] !== sent_bits[i]) mism++;
    end
    chk({tag, " bit value errors"}, mism, 0);
    chk({tag, " sync_found count"}, got_nsync - b_sync, exp_nsync);
    chk({tag, " run_err count"}, got_nrun - b_run, exp_nrun);
    chk({tag, " run_err without lock fall"}, got_rl_bad - b_rl, 0);
    chk({tag, " byte count"}, nby, exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      chk($sformatf("%s byte %0d", tag, i),
          (i < nby) ? {24'h0, got_bytes[b_bytes + i]} : 32'hDEAD, {24'h0, exp_bytes[i]});
    end
    chk({tag, " lock"}, lock, exp_lock);
  endtask

  task automatic check_intervals(input string tag);
    int nb;
    int mism;
    nb = got_bit_cyc.size() - b_bits;
    mism = 0;
    for (int i = 1; i < nb; i++) begin
      if (got_bit_cyc[b_bits + i] - got_bit_cyc[b_bits + i - 1] != OS) mism++;
    end
    chk({tag, " bit spacing errors"}, mism, 0);
  endtask

  initial begin
    logic [7:0] rb;

    // reset with the line toggling
    pll_locked = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = ~serial_in;
      @(negedge clk);
    end
    serial_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset bit_valid", bit_valid, 0);
    chk("reset bit_data", bit_data, 0);
    chk("reset lock", lock, 0);
    chk("reset sync_found", sync_found, 0);
    chk("reset byte_data", byte_data, 0);
    chk("reset byte_valid", byte_valid, 0);
    chk("reset run_err", run_err, 0);

    // nominal frame
    begin_scn();
    send_frame_head(OS);
    send_byte(8'h3C, OS, -1);
    send_byte(8'hA5, OS, -1);
    check_scn("nominal");
    check_intervals("nominal");

    // random payload, biased toward long runs
    do_reset();
    begin_scn();
    send_frame_head(OS);
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      send_byte(rb, OS, -1);
    end
    check_scn("random");
    check_intervals("random");

    // drift tolerance: short then long bit periods
    do_reset();
    begin_scn();
    send_frame_head(OS);
    send_byte(8'h3C, OS, -1);
    send_byte(8'hA5, OS, -1);
    for (int i = 0; i < 64; i++) begin
      rb = ($urandom_range(0, 1) == 0) ? 8'h55 : 8'h0F;
      send_byte(rb, (i < 32) ? OS - 1 : OS + 1, -1);
    end
    check_scn("drift");

    // run-length violation, then relock
    do_reset();
    begin_scn();
    send_frame_head(OS);
    send_byte(8'h3C, OS, -1);
    for (int i = 0; i < 16; i++) send_bit(1'b1, OS, -1);
    send_byte(8'h5A, OS, -1);
    send_byte(8'h5A, OS, -1);
    send_byte(SYNC[15:8], OS, -1);
    send_byte(SYNC[7:0], OS, -1);
    send_byte(8'h81, OS, -1);
    check_scn("runlen");

    // pll lock lost mid-byte, sync ignored while low, then relock
    do_reset();
    begin_scn();
    send_frame_head(OS);
    send_byte(8'h3C, OS, -1);
    send_bit(1'b1, OS, -1);
    send_bit(1'b1, OS, -1);
    send_bit(1'b1, OS, -1);
    send_bit(1'b1, OS, -1);
    send_bit(1'b0, OS, -1);
    chk("pll lock before drop", lock, 1);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("pll lock after drop", lock, 0);
    send_bit(1'b0, OS - 3, -1);
    send_bit(1'b0, OS, -1);
    send_bit(1'b0, OS, -1);
    send_byte(SYNC[15:8], OS, -1);
    send_byte(SYNC[7:0], OS, -1);
    chk("pll sync ignored", lock, 0);
    pll_locked = 1'b1;
    send_byte(8'hAA, OS, -1);
    send_byte(SYNC[15:8], OS, -1);
    send_byte(SYNC[7:0], OS, -1);
    send_byte(8'h81, OS, -1);
    check_scn("pll");

    // single-cycle glitches inside constant-0 bits
    do_reset();
    begin_scn();
    send_frame_head(OS);
    send_byte(8'h3C, OS, 30);
    send_byte(8'h00, OS, 30);
    check_scn("glitch");
    check_intervals("glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
